// File: rtl/shot_sequencer.sv
// shot_sequencer: round/shot controller for the cannon game (fire, wait for result, score, ammo).
// Optional feature macro STREAK_BONUS_EN: consecutive-hit bonus scoring via a 2-bit streak counter.
module shot_sequencer #(
  parameter int SHOTS   = 8,
  parameter int TIMEOUT = 64,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start_new_game,
  input  logic               shoot_req,
  input  logic               result_valid,
  input  logic               hit,
  output logic               shoot_out,
  output logic               new_target,
  output logic               busy,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         shots_left,
  output logic               game_over,
  output logic               timeout_err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_READY   = 3'd2,
    S_FIRE    = 3'd3,
    S_WAIT    = 3'd4,
    S_RESOLVE = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               shoot_req_q;
  logic               hit_q;
  logic               rise;
  logic               wait_done;
  logic [7:0]         cnt_q;
  logic [1:0]         incr;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_inc;

  assign rise      = shoot_req & ~shoot_req_q;
  assign wait_done = (cnt_q == 8'(TIMEOUT - 1));

`ifdef STREAK_BONUS_EN
  logic [1:0] streak_q;

  // Third and later consecutive hits are worth double.
  assign incr = (streak_q >= 2'd2) ? 2'd2 : 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= 2'd0;
    end else if (ena) begin
      if (state_q == S_LOAD) begin
        streak_q <= 2'd0;
      end else if (state_q == S_RESOLVE) begin
        if (!hit_q)                streak_q <= 2'd0;
        else if (streak_q != 2'd3) streak_q <= streak_q + 2'd1;
      end
    end
  end
`else
  assign incr = 2'd1;
`endif

  assign score_sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, incr};
  assign score_inc = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d    = state_q;
    shoot_out  = 1'b0;
    new_target = 1'b0;
    busy       = 1'b0;
    game_over  = 1'b0;
    dbg_state  = state_q;
    case (state_q)
      S_IDLE:  ;
      S_LOAD: begin
        new_target = ena;
        state_d    = S_READY;
      end
      S_READY: begin
        if (rise && (shots_left != 4'd0)) state_d = S_FIRE;
      end
      S_FIRE: begin
        shoot_out = ena;
        busy      = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (result_valid || wait_done) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        busy       = 1'b1;
        new_target = ena & hit_q;
        state_d    = (shots_left == 4'd0) ? S_OVER : S_READY;
      end
      S_OVER: begin
        game_over = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Restart beats every other transition, including an outstanding shot.
    if (start_new_game) state_d = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      score       <= '0;
      shots_left  <= 4'(SHOTS);
      timeout_err <= 1'b0;
      shoot_req_q <= 1'b0;
      cnt_q       <= 8'd0;
      hit_q       <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      shoot_req_q <= shoot_req;
      case (state_q)
        S_LOAD: begin
          score       <= '0;
          shots_left  <= 4'(SHOTS);
          timeout_err <= 1'b0;
        end
        S_FIRE: begin
          shots_left <= shots_left - 4'd1;
          cnt_q      <= 8'd0;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // A result arriving on the timeout cycle wins; the error flag is left alone.
          if (result_valid) begin
            hit_q <= hit;
          end else if (wait_done) begin
            timeout_err <= 1'b1;
            hit_q       <= 1'b0;
          end
        end
        S_RESOLVE: begin
          if (hit_q) score <= score_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: per-cycle vector table plus directed multi-cycle sequences.
module tb_shot_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_READY = 3'd2, ST_FIRE = 3'd3,
                         ST_WAIT = 3'd4, ST_RES  = 3'd5, ST_OVER  = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start_new_game = 1'b0;
  logic       shoot_req = 1'b0;
  logic       result_valid = 1'b0;
  logic       hit = 1'b0;
  logic       shoot_out, new_target, busy, game_over, timeout_err;
  logic [7:0] score;
  logic [3:0] shots_left;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  shot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start_new_game(start_new_game),
    .shoot_req(shoot_req), .result_valid(result_valid), .hit(hit),
    .shoot_out(shoot_out), .new_target(new_target), .busy(busy), .score(score),
    .shots_left(shots_left), .game_over(game_over), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       ena, start, shoot, rv, hit;
    logic       so, nt, busy, go, te;
    logic [7:0] score;
    logic [3:0] shots;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, s, sh, rv, h, so, nt, b, go, te,
                              input logic [7:0] sc, input logic [3:0] sl, input logic [2:0] st);
    vec_t v;
    v.ena = e; v.start = s; v.shoot = sh; v.rv = rv; v.hit = h;
    v.so = so; v.nt = nt; v.busy = b; v.go = go; v.te = te;
    v.score = sc; v.shots = sl; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks; all start and end at posedge+1
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart();
    start_new_game = 1'b1;
    cyc(1);
    start_new_game = 1'b0;
    cyc(1);
  endtask

  task automatic fire();
    shoot_req = 1'b1;
    cyc(1);
    shoot_req = 1'b0;
    @(negedge clk);
    chk("fire_pulse", {31'd0, shoot_out}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Result arrives in the k-th WAIT cycle (k=1 is the cycle right after FIRE).
  task automatic resolve(input int k, input logic h);
    cyc(k - 1);
    result_valid = 1'b1;
    hit = h;
    cyc(1);
    result_valid = 1'b0;
    hit = 1'b0;
    chk("resolve_state", {29'd0, dbg_state}, {29'd0, ST_RES});
    @(negedge clk);
    chk("resolve_nt", {31'd0, new_target}, {31'd0, h});
    @(posedge clk);
    #1;
  endtask

  task automatic count_wait(output int n);
    n = 0;
    while (dbg_state == ST_WAIT && n < 300) begin
      n++;
      cyc(1);
    end
  endtask

  initial begin
    int n;
    int pulses;
    int exp_score[6];

    //          ena st sh rv h | so nt b go te score shots state
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 4'd8, ST_IDLE));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 4'd8, ST_IDLE));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0, 4'd8, ST_LOAD));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 4'd8, ST_READY));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'd0, 4'd8, ST_FIRE));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 4'd7, ST_WAIT));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 4'd7, ST_WAIT));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 8'd0, 4'd7, ST_WAIT));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'd0, 4'd7, ST_RES));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1, 4'd7, ST_READY));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1, 4'd7, ST_READY));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'd1, 4'd7, ST_FIRE));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1, 4'd6, ST_WAIT));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 8'd1, 4'd6, ST_WAIT));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'd1, 4'd6, ST_RES));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1, 4'd6, ST_READY));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8'd1, 4'd6, ST_READY));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'd1, 4'd6, ST_READY));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1, 4'd6, ST_READY));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1, 4'd6, ST_READY));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'd1, 4'd6, ST_FIRE));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'd1, 4'd6, ST_FIRE));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1, 4'd5, ST_WAIT));

`ifdef STREAK_BONUS_EN
    exp_score = '{1, 2, 4, 6, 6, 7};
`else
    exp_score = '{1, 2, 3, 4, 4, 5};
`endif

    // reset held for two clocks
    cyc(2);
    @(negedge clk);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_score", {24'd0, score}, 32'd0);
    chk("rst_shots", {28'd0, shots_left}, 32'd8);
    chk("rst_flags", {27'd0, shoot_out, new_target, busy, game_over, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // per-cycle vectors: inputs applied at posedge+1, outputs checked at negedge
    for (int i = 0; i < tbl.size(); i++) begin
      ena = tbl[i].ena;
      start_new_game = tbl[i].start;
      shoot_req = tbl[i].shoot;
      result_valid = tbl[i].rv;
      hit = tbl[i].hit;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {12'd0, shoot_out, new_target, busy, game_over, timeout_err, score, shots_left, dbg_state},
          {12'd0, tbl[i].so, tbl[i].nt, tbl[i].busy, tbl[i].go, tbl[i].te, tbl[i].score,
           tbl[i].shots, tbl[i].st});
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    shoot_req = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;

    // eight misses end the game; a further request is dropped
    restart();
    for (int s = 0; s < 8; s++) begin
      fire();
      resolve(2, 1'b0);
    end
    chk("over_state", {29'd0, dbg_state}, {29'd0, ST_OVER});
    chk("over_flag", {31'd0, game_over}, 32'd1);
    chk("over_shots", {28'd0, shots_left}, 32'd0);
    chk("over_score", {24'd0, score}, 32'd0);
    pulses = 0;
    shoot_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pulses += int'(shoot_out);
      @(posedge clk);
      #1;
    end
    shoot_req = 1'b0;
    chk("over_no_fire", pulses, 0);
    chk("over_hold", {29'd0, dbg_state}, {29'd0, ST_OVER});

    // timeout after TIMEOUT cycles in WAIT
    restart();
    fire();
    count_wait(n);
    chk("timeout_len", n, 64);
    chk("timeout_err", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    chk("timeout_no_nt", {31'd0, new_target}, 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_score", {24'd0, score}, 32'd0);
    chk("timeout_shots", {28'd0, shots_left}, 32'd7);

    // result on the last WAIT cycle beats the timeout
    restart();
    chk("load_clears_err", {31'd0, timeout_err}, 32'd0);
    fire();
    resolve(64, 1'b1);
    chk("late_score", {24'd0, score}, 32'd1);
    chk("late_no_err", {31'd0, timeout_err}, 32'd0);

    // ena low in WAIT freezes the counter and defers the timeout
    fire();
    cyc(5);
    ena = 1'b0;
    cyc(10);
    chk("freeze_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    ena = 1'b1;
    count_wait(n);
    chk("freeze_remaining", n, 59);
    chk("freeze_err", {31'd0, timeout_err}, 32'd1);

    // held / re-rising shoot_req while busy fires once; restart mid-WAIT drops the late result
    restart();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      shoot_req = (i != 3 && i != 6);
      @(negedge clk);
      pulses += int'(shoot_out);
      @(posedge clk);
      #1;
    end
    shoot_req = 1'b0;
    chk("one_shot", pulses, 1);
    chk("mid_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    start_new_game = 1'b1;
    cyc(1);
    start_new_game = 1'b0;
    result_valid = 1'b1;
    hit = 1'b1;
    cyc(2);
    result_valid = 1'b0;
    hit = 1'b0;
    chk("restart_state", {29'd0, dbg_state}, {29'd0, ST_READY});
    chk("restart_score", {24'd0, score}, 32'd0);
    chk("restart_shots", {28'd0, shots_left}, 32'd8);

    // hit streak, then a miss, then a hit
    for (int s = 0; s < 6; s++) begin
      fire();
      resolve(3, (s != 4));
      chk($sformatf("streak%0d", s), {24'd0, score}, exp_score[s]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
